bin2bcd_seq: RTL and testbench

//  Sequential double-dabble binary-to-BCD converter; sits directly upstream of the sseg

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 137 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : converter FSM states
//   DIGIT_W    : bits per BCD digit
//   ADJ_THRESH : digit value at or above which the double-dabble correction applies
//   ADJ_ADD    : correction added to such a digit before each shift
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: one BCD digit in, the digit plus 3 out when it is
// 5 or more (so the following left shift carries correctly into the next digit).
//   in_i  : BCD digit before correction
//   out_o : corrected digit
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] in_i,
  output logic [DIGIT_W-1:0] out_o
);

  assign out_o = (in_i >= ADJ_THRESH) ? (in_i + ADJ_ADD) : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment driver.
// One conversion at a time with a start/busy/done handshake; a W-bit value takes
// W shift cycles plus one DONE cycle, and the result lands one edge later.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, only honoured in IDLE
//   bin      : binary value, captured when start is accepted
//   busy     : high while shifting and during the DONE cycle
//   done     : one-cycle pulse when bcd/overflow are updated
//   bcd      : DIGITS packed BCD digits, digit 0 in [3:0], stable between dones
//   overflow : bin >= 10**DIGITS; bcd then holds the low DIGITS digits
// Optional build macro BIN2BCD_AUTO_EN: a change of bin while IDLE starts a conversion
// on its own, so the display follows switches without an external strobe.
// W must be at least 2.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [W-1:0]              bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow
);

  localparam int               BCD_W    = DIGIT_W * DIGITS;
  localparam int               CNT_W    = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovfl_q, ovfl_d;
  logic               done_q, done_d;
  logic               start_int;

`ifdef BIN2BCD_AUTO_EN
  logic [W-1:0] last_bin_q, last_bin_d;

  // A value differing from the last converted one counts as a request while IDLE.
  assign start_int  = start | ((state_q == IDLE) && (bin != last_bin_q));
  assign last_bin_d = ((state_q == IDLE) && start_int) ? bin : last_bin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_bin_q <= '0;
    else        last_bin_q <= last_bin_d;
  end
`else
  assign start_int = start;
`endif

  // Per-digit +3 correction applied to the scratch register ahead of every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .in_i  (scr_q[g*DIGIT_W +: DIGIT_W]),
      .out_o (scr_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    bcd_d    = bcd_q;
    ovfl_d   = ovfl_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_int) begin
          state_d  = SHIFT;
          bin_sr_d = bin;
          scr_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      SHIFT: begin
        // Shift {scratch, binary} left by one; the bit pushed out of the top digit
        // means the value no longer fits in DIGITS digits.
        scr_d    = {scr_adj[BCD_W-2:0], bin_sr_q[W-1]};
        bin_sr_d = {bin_sr_q[W-2:0], 1'b0};
        ovf_d    = ovf_q | scr_adj[BCD_W-1];
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        bcd_d   = scr_q;
        ovfl_d  = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_sr_q <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      ovfl_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      scr_q    <= scr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      bcd_q    <= bcd_d;
      ovfl_q   <= ovfl_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT) || (state_q == DONE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovfl_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit instance and a 16-bit instance share
// clock and reset; outputs are sampled on the falling edge.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        busy8, done8, ovf8;
  logic        busy16, done16, ovf16;
  logic [15:0] bcd8, bcd16;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.W(8), .DIGITS(4)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .bin      (bin8),
    .busy     (busy8),
    .done     (done8),
    .bcd      (bcd8),
    .overflow (ovf8)
  );

  bin2bcd_seq #(.W(16), .DIGITS(4)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .bin      (bin16),
    .busy     (busy16),
    .done     (done16),
    .bcd      (bcd16),
    .overflow (ovf16)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start, then watch a fixed 30-cycle window.
  // lat = edges from the start edge to the edge that raises done.
  task automatic run_conv(input bit sel, input logic [15:0] b, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input int exp_lat, input string tag);
    int          busy_n;
    int          done_n;
    int          lat;
    logic [15:0] bcd_at;
    logic        ovf_at;
    busy_n = 0;
    done_n = 0;
    lat    = -1;
    bcd_at = '0;
    ovf_at = 1'b0;
    if (sel) begin bin16 = b; start16 = 1'b1; end
    else     begin bin8 = b[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (sel ? busy16 : busy8) busy_n++;
      if (sel ? done16 : done8) begin
        done_n++;
        if (lat < 0) begin
          lat    = i - 1;
          bcd_at = sel ? bcd16 : bcd8;
          ovf_at = sel ? ovf16 : ovf8;
        end
      end
      @(negedge clk);
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_n, exp_lat);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".bcd"}, {16'h0, bcd_at}, {16'h0, exp_bcd});
    check({tag, ".ovf"}, {31'h0, ovf_at}, {31'h0, exp_ovf});
    check({tag, ".bcd_held"}, {16'h0, (sel ? bcd16 : bcd8)}, {16'h0, exp_bcd});
  endtask

  initial begin
    int          dn;
    logic [15:0] bcd_at;
    rst_n   = 1'b0;
    start8  = 1'b0;
    start16 = 1'b0;
    bin8    = '0;
    bin16   = '0;
    repeat (3) @(negedge clk);

    check("rst.busy8", {31'h0, busy8}, 32'h0);
    check("rst.done8", {31'h0, done8}, 32'h0);
    check("rst.bcd8", {16'h0, bcd8}, 32'h0);
    check("rst.ovf8", {31'h0, ovf8}, 32'h0);
    check("rst.busy16", {31'h0, busy16}, 32'h0);
    check("rst.bcd16", {16'h0, bcd16}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(1'b0, 16'd255, 16'h0255, 1'b0, 9, "w8_255");
    run_conv(1'b0, 16'd0, 16'h0000, 1'b0, 9, "w8_0");
    run_conv(1'b0, 16'd99, 16'h0099, 1'b0, 9, "w8_99");
    run_conv(1'b0, 16'd128, 16'h0128, 1'b0, 9, "w8_128");
    run_conv(1'b1, 16'd10000, 16'h0000, 1'b1, 17, "w16_10000");
    run_conv(1'b1, 16'd9999, 16'h9999, 1'b0, 17, "w16_9999");
    run_conv(1'b1, 16'd65535, 16'h5535, 1'b1, 17, "w16_65535");

`ifndef BIN2BCD_AUTO_EN
    // start held high through the run, bin changed mid-conversion
    dn     = 0;
    bcd_at = '0;
    bin8   = 8'd123;
    start8 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done8) begin
        dn++;
        if (dn == 1) bcd_at = bcd8;
      end
      if (i == 3) bin8 = 8'd7;
      if (i == 9) start8 = 1'b0;
    end
    check("hold.done_pulses", dn, 1);
    check("hold.bcd", {16'h0, bcd_at}, 32'h0123);

    // reset in the middle of a conversion
    bin8   = 8'd200;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", {31'h0, busy8}, 32'h0);
    check("midrst.bcd", {16'h0, bcd8}, 32'h0);
    check("midrst.done", {31'h0, done8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("midrst.no_done", dn, 0);
    run_conv(1'b0, 16'd200, 16'h0200, 1'b0, 9, "w8_200_after_rst");
`else
    // start tied low: a new bin value converts by itself, a steady one does not
    dn     = 0;
    bcd_at = '0;
    bin8   = 8'd42;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        dn++;
        if (dn == 1) bcd_at = bcd8;
      end
    end
    check("auto.done_pulses", dn, 1);
    check("auto.bcd", {16'h0, bcd_at}, 32'h0042);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("auto.steady_no_done", dn, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
